// File: rtl/cordic_pkg.sv
// Shared constants for the rotation-mode CORDIC: arctangent table, quarter-turn
// angle and the Q15 inverse-gain factor used by the optional compensation stage.
package cordic_pkg;

    localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
    localparam logic [15:0] GAIN_INV_Q15 = 16'd19898;

    // round(atan(2^-i) * 2^32 / (2*pi)), i = 0..31
    localparam logic [31:0] ATAN_TABLE [0:31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation: shift index SHIFT, arctangent step ATAN.
module cordic_stage #(
    parameter int                 WIDTH = 16,
    parameter int                 SHIFT = 0,
    parameter logic signed [31:0] ATAN  = 32'sh2000_0000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic signed [WIDTH:0]   i_x,
    input  logic signed [WIDTH:0]   i_y,
    input  logic signed [31:0]      i_z,
    output logic signed [WIDTH:0]   o_x,
    output logic signed [WIDTH:0]   o_y,
    output logic signed [31:0]      o_z
);

    logic signed [WIDTH:0] w_xShift;
    logic signed [WIDTH:0] w_yShift;

    assign w_xShift = i_x >>> SHIFT;
    assign w_yShift = i_y >>> SHIFT;

    // A negative residual angle means we overshot, so rotate back clockwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_x <= '0;
            o_y <= '0;
            o_z <= '0;
        end else if (i_z[31]) begin
            o_x <= i_x + w_yShift;
            o_y <= i_y - w_xShift;
            o_z <= i_z + ATAN;
        end else begin
            o_x <= i_x - w_yShift;
            o_y <= i_y + w_xShift;
            o_z <= i_z - ATAN;
        end
    end

endmodule

// File: rtl/cordic.sv
// Fully pipelined rotation-mode CORDIC, one sample per clock, latency WIDTH.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensating output register (latency WIDTH+1).
module cordic
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic signed [WIDTH-1:0]   x_start,
    input  logic signed [WIDTH-1:0]   y_start,
    input  logic signed [ANGLE_W-1:0] angle,
    output logic signed [WIDTH-1:0]   cosine,
    output logic signed [WIDTH-1:0]   sine
);

    logic signed [WIDTH:0]     x [0:WIDTH-1];
    logic signed [WIDTH:0]     y [0:WIDTH-1];
    logic signed [ANGLE_W-1:0] z [0:WIDTH-1];

    logic signed [WIDTH:0]     r_x0;
    logic signed [WIDTH:0]     r_y0;
    logic signed [ANGLE_W-1:0] r_z0;
    logic signed [WIDTH:0]     w_xExt;
    logic signed [WIDTH:0]     w_yExt;

    assign w_xExt = {x_start[WIDTH-1], x_start};
    assign w_yExt = {y_start[WIDTH-1], y_start};

    // Fold the angle into +/-90 degrees so the micro-rotations converge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_z0 <= '0;
        end else begin
            case (angle[ANGLE_W-1 -: 2])
                2'b01: begin
                    r_x0 <= -w_yExt;
                    r_y0 <= w_xExt;
                    r_z0 <= angle - QUARTER_TURN;
                end
                2'b10: begin
                    r_x0 <= w_yExt;
                    r_y0 <= -w_xExt;
                    r_z0 <= angle + QUARTER_TURN;
                end
                default: begin
                    r_x0 <= w_xExt;
                    r_y0 <= w_yExt;
                    r_z0 <= angle;
                end
            endcase
        end
    end

    assign x[0] = r_x0;
    assign y[0] = r_y0;
    assign z[0] = r_z0;

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_stage
        cordic_stage #(
            .WIDTH (WIDTH),
            .SHIFT (i),
            .ATAN  (ATAN_TABLE[i])
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .i_x     (x[i]),
            .i_y     (y[i]),
            .i_z     (z[i]),
            .o_x     (x[i+1]),
            .o_y     (y[i+1]),
            .o_z     (z[i+1])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = WIDTH + 18;

    logic signed [PW-1:0]    w_xProd;
    logic signed [PW-1:0]    w_yProd;
    logic signed [WIDTH-1:0] r_cos;
    logic signed [WIDTH-1:0] r_sin;
    logic                    w_unused;

    assign w_xProd = x[WIDTH-1] * $signed({1'b0, GAIN_INV_Q15});
    assign w_yProd = y[WIDTH-1] * $signed({1'b0, GAIN_INV_Q15});

    // Q15 multiply by 1/K strips the CORDIC gain from both outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cos <= '0;
            r_sin <= '0;
        end else begin
            r_cos <= w_xProd[WIDTH+14:15];
            r_sin <= w_yProd[WIDTH+14:15];
        end
    end

    assign cosine   = r_cos;
    assign sine     = r_sin;
    assign w_unused = ^{w_xProd, w_yProd, z[WIDTH-1]};
`else
    logic w_unused;

    assign cosine   = x[WIDTH-1][WIDTH-1:0];
    assign sine     = y[WIDTH-1][WIDTH-1:0];
    assign w_unused = ^{x[WIDTH-1][WIDTH], y[WIDTH-1][WIDTH], z[WIDTH-1]};
`endif

endmodule

// File: tb/tb_cordic.sv
// Directed self-checking bench for cordic: quadrant angles, back-to-back stream
// and asynchronous mid-stream reset with pipeline refill.
module tb_cordic;

    localparam int WIDTH = 16;
    localparam int TOL   = 4;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = WIDTH + 1;
    localparam int A0  = 16384;
    localparam int C30 = 14189;
    localparam int S30 = 8192;
    localparam int C45 = 11585;
`else
    localparam int LAT = WIDTH;
    localparam int A0  = 26981;
    localparam int C30 = 23366;
    localparam int S30 = 13490;
    localparam int C45 = 19078;
`endif

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic signed [WIDTH-1:0] x_start = '0;
    logic signed [WIDTH-1:0] y_start = '0;
    logic signed [31:0]      angle = '0;
    logic signed [WIDTH-1:0] cosine;
    logic signed [WIDTH-1:0] sine;

    int nVectors = 0;
    int nMiscompares = 0;

    cordic #(.WIDTH(WIDTH), .ANGLE_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .x_start (x_start),
        .y_start (y_start),
        .angle   (angle),
        .cosine  (cosine),
        .sine    (sine)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit near(input logic signed [WIDTH-1:0] act, input int exp);
        int a;
        if ($isunknown(act)) return 1'b0;
        a = act;
        return (a - exp <= TOL) && (exp - a <= TOL);
    endfunction

    function automatic bit pipeZero();
        bit ok = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (dut.x[i] !== '0 || dut.y[i] !== '0 || dut.z[i] !== '0) ok = 1'b0;
        end
        return ok;
    endfunction

    // Drive one sample for one clock, then zeros; return outputs LAT clocks later.
    task automatic applyStimulus(input int xs, input int ys, input logic [31:0] ang,
                                 output logic signed [WIDTH-1:0] c,
                                 output logic signed [WIDTH-1:0] s,
                                 output logic signed [31:0] zLast);
        @(negedge clock);
        x_start = WIDTH'(xs);
        y_start = WIDTH'(ys);
        angle   = ang;
        zLast   = '0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            if (k == 1) begin
                x_start = '0;
                y_start = '0;
                angle   = '0;
            end
            if (k == WIDTH) zLast = dut.z[WIDTH-1];
        end
        c = cosine;
        s = sine;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        nVectors++;
        if (cosine !== '0 || sine !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_out: got cos=%0d sin=%0d, required 0/0", cosine, sine);
        end
        nVectors++;
        if (!pipeZero()) begin
            nMiscompares++;
            $display("[TB] FAIL reset_pipe: got nonzero x/y/z stage (z0=%h), required all 0", dut.z[0]);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_angles();
        logic signed [WIDTH-1:0] c, s;
        logic signed [31:0] zl;
        logic [31:0] angs [5] = '{32'h0000_0000, 32'h1555_5555, 32'h4000_0000,
                                  32'h8000_0000, 32'hC000_0000};
        int expC [5] = '{A0, C30, 0, -A0, 0};
        int expS [5] = '{0, S30, A0, 0, -A0};
        for (int v = 0; v < 5; v++) begin
            applyStimulus(16384, 0, angs[v], c, s, zl);
            nVectors++;
            if (!near(c, expC[v]) || !near(s, expS[v])) begin
                nMiscompares++;
                $display("[TB] FAIL angle_%h: got cos=%0d sin=%0d, required %0d/%0d (+/-%0d)",
                         angs[v], c, s, expC[v], expS[v], TOL);
            end
            if (v == 0) begin
                nVectors++;
                if ($isunknown(zl) || zl > 32'sd131072 || zl < -32'sd131072) begin
                    nMiscompares++;
                    $display("[TB] FAIL z_residual: got z[15]=%0d, required |z| <= 131072", zl);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] angs [5] = '{32'h0000_0000, 32'h1555_5555, 32'h2000_0000,
                                  32'h2AAA_AAAB, 32'h4000_0000};
        int expC [5] = '{A0, C30, C45, S30, 0};
        int expS [5] = '{0, S30, C45, C30, A0};
        for (int m = 0; m < LAT + 5; m++) begin
            @(negedge clock);
            if (m >= LAT) begin
                nVectors++;
                if (!near(cosine, expC[m-LAT]) || !near(sine, expS[m-LAT])) begin
                    nMiscompares++;
                    $display("[TB] FAIL b2b_%0d: got cos=%0d sin=%0d, required %0d/%0d",
                             m - LAT, cosine, sine, expC[m-LAT], expS[m-LAT]);
                end
            end
            if (m < 5) begin
                x_start = 16'sd16384;
                y_start = '0;
                angle   = angs[m];
            end else begin
                x_start = '0;
                angle   = '0;
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int m = 0; m < 8; m++) begin
            @(negedge clock);
            x_start = 16'sd16384;
            angle   = 32'h1555_5555;
        end
        #2 reset_n = 1'b0;
        #1;
        nVectors++;
        if (cosine !== '0 || sine !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL async_reset_out: got cos=%0d sin=%0d, required 0/0", cosine, sine);
        end
        nVectors++;
        if (!pipeZero()) begin
            nMiscompares++;
            $display("[TB] FAIL async_reset_pipe: got nonzero x/y/z stage (z3=%h), required all 0", dut.z[3]);
        end
        @(negedge clock);
        reset_n = 1'b1;
        x_start = 16'sd16384;
        angle   = 32'h4000_0000;
        for (int m = 1; m <= LAT; m++) begin
            @(negedge clock);
            if (m == 1) begin
                x_start = '0;
                angle   = '0;
            end
            if (m == LAT - 1) begin
                nVectors++;
                if (cosine !== '0 || sine !== '0) begin
                    nMiscompares++;
                    $display("[TB] FAIL refill_early: got cos=%0d sin=%0d, required 0/0", cosine, sine);
                end
            end
            if (m == LAT) begin
                nVectors++;
                if (!near(cosine, 0) || !near(sine, A0)) begin
                    nMiscompares++;
                    $display("[TB] FAIL refill_first: got cos=%0d sin=%0d, required 0/%0d", cosine, sine, A0);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] cordic bench start, latency %0d", LAT);
        test_reset();
        test_angles();
        test_back_to_back();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
